mem_word_fetch: RTL and testbench

Multi-beat memory read sequencer that sits directly upstream of the processor's load/store register. It fetches one n-bit word from a narrow m-bit memory bus in n/m consecutive address beats over a req/ack handshake. It assembles the beats little-endian and presents the finished word with a one-cycle active-low load strobe. A per-beat timeout aborts stalled reads so the control unit never hangs.

---
 rtl/mem_word_fetch.sv | 130 +++++++++++++
 tb/tb_mem_word_fetch.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_word_fetch.sv
// mem_word_fetch: multi-beat memory read sequencer.
//
// Fetches one n-bit word as k = n/m consecutive m-bit beats over a req/ack
// handshake. Beat i is read from (base + i) mod 2^a. Beats are assembled
// little-endian, so beat 0 lands in the LSBs. The finished word is announced
// with a one-cycle active-low load strobe. If a beat goes unacknowledged for
// `to` consecutive cycles, the fetch is abandoned and err pulses for one cycle.
//
// Ports:
//   clk       in   clock, rising edge
//   clr       in   asynchronous active-low reset
//   start     in   fetch request, sampled only while idle
//   addr      in   [a-1:0] base address, captured with start
//   mem_req   out  read request to memory
//   mem_addr  out  [a-1:0] address of the current beat
//   mem_ack   in   beat accepted; mem_data is valid with mem_req & mem_ack
//   mem_data  in   [m-1:0] beat data
//   out       out  [n-1:0] assembled word, held until overwritten
//   ld        out  active-low load strobe, one cycle per completed fetch
//   busy      out  high whenever not idle
//   err       out  one-cycle pulse after a beat timeout
module mem_word_fetch #(
    parameter int unsigned n  = 8,
    parameter int unsigned m  = 4,
    parameter int unsigned a  = 8,
    parameter int unsigned to = 15
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic [a-1:0] addr,
    output logic         mem_req,
    output logic [a-1:0] mem_addr,
    input  logic         mem_ack,
    input  logic [m-1:0] mem_data,
    output logic [n-1:0] out,
    output logic         ld,
    output logic         busy,
    output logic         err
);

    localparam int unsigned K  = n / m;
    localparam int unsigned BW = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned WW = $clog2(to + 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StLoad
    } state_e;

    state_e          state_q, state_d;
    logic [a-1:0]    base_q,  base_d;
    logic [BW-1:0]   beat_q,  beat_d;
    logic [WW-1:0]   wait_q,  wait_d;
    logic [n-1:0]    out_q,   out_d;
    logic            err_q,   err_d;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= StIdle;
            base_q  <= '0;
            beat_q  <= '0;
            wait_q  <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        out_d   = out_q;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d  = addr;
                    beat_d  = '0;
                    wait_d  = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (mem_ack) begin
                    out_d[int'(beat_q) * m +: m] = mem_data;
                    wait_d = '0;
                    if (beat_q == BW'(K - 1)) begin
                        state_d = StLoad;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end else if (wait_q == WW'(to - 1)) begin
                    // This is the to-th cycle without ack: abandon the fetch.
                    // Beats already written into out are deliberately kept.
                    wait_d  = '0;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StLoad: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign mem_req  = (state_q == StReq);
    // Address wraps naturally at 2^a.
    assign mem_addr = base_q + a'(beat_q);
    assign out      = out_q;
    assign ld       = (state_q != StLoad);
    assign busy     = (state_q != StIdle);
    assign err      = err_q;

endmodule

// File: tb/tb_mem_word_fetch.sv
module tb_mem_word_fetch;

    localparam int unsigned TO = 15;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic [7:0] addr;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [3:0] mem_data;
    logic [7:0] out;
    logic       ld;
    logic       busy;
    logic       err;

    mem_word_fetch #(
        .n  (8),
        .m  (4),
        .a  (8),
        .to (TO)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .addr     (addr),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .out      (out),
        .ld       (ld),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Memory model: ack arrives after ack_delay cycles of an outstanding request.
    logic [3:0] mem [256];
    int         ack_delay = 0;
    bit         ack_en    = 1'b1;
    int         ack_cnt   = 0;
    int         cyc       = 0;

    assign mem_ack  = ack_en && mem_req && (ack_cnt >= ack_delay);
    assign mem_data = mem[mem_addr];

    typedef struct {
        bit         is_to;
        logic [7:0] word;
        int         cyc;
    } sb_t;

    sb_t        q[$];
    sb_t        it_p;
    sb_t        it_m;
    logic [7:0] exp_addr = '0;
    logic [7:0] nxt_addr;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Edge-side model: cycle count, ack timing, scoreboard pushes, beat addresses.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_req || mem_ack) ack_cnt <= 0;
        else                     ack_cnt <= ack_cnt + 1;

        if (clr && start && !busy) begin
            nxt_addr    = addr + 8'd1;
            it_p.is_to  = !ack_en;
            it_p.word   = {mem[nxt_addr], mem[addr]};
            it_p.cyc    = ack_en ? (cyc + 1 + 2 * (ack_delay + 1)) : (cyc + 1 + int'(TO));
            q.push_back(it_p);
            exp_addr   <= addr;
        end

        if (clr && mem_req && mem_ack) begin
            check("beat_addr", {24'd0, mem_addr}, {24'd0, exp_addr});
            exp_addr <= exp_addr + 8'd1;
        end
    end

    // Output-side monitor: every ld pulse and err pulse must match a queued entry.
    always @(negedge clk) begin
        if (clr && !ld) begin
            check("ld_queued", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                it_m = q.pop_front();
                check("ld_kind", 32'(it_m.is_to), 32'd0);
                check("ld_cycle", cyc, it_m.cyc);
                check("ld_word", {24'd0, out}, {24'd0, it_m.word});
            end
        end
        if (clr && err) begin
            check("err_queued", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                it_m = q.pop_front();
                check("err_kind", 32'(it_m.is_to), 32'd1);
                check("err_cycle", cyc, it_m.cyc);
            end
        end
    end

    task automatic launch(input logic [7:0] ad);
        @(negedge clk);
        #1;
        start = 1'b1;
        addr  = ad;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (!busy && q.size() == 0) break;
        end
        check(tag, 32'(i < budget), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out"},  {24'd0, out}, 32'h00);
        check({tag, "_ld"},   32'(ld), 32'd1);
        check({tag, "_req"},  32'(mem_req), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"},  32'(err), 32'd0);
    endtask

    initial begin
        bit req_drop;
        int i;

        #200000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit req_drop;
        int i;

        for (int j = 0; j < 256; j++) mem[j] = 4'($urandom);
        mem[8'h10] = 4'hA; mem[8'h11] = 4'h5;
        mem[8'hFF] = 4'h7; mem[8'h00] = 4'hE;
        mem[8'h50] = 4'h3; mem[8'h51] = 4'hC;

        clr   = 1'b1;
        start = 1'b0;
        addr  = '0;

        // Reset asserted between edges must act without a clock edge.
        #2 clr = 1'b0;
        #1 check_reset_outputs("reset");
        check("reset_addr", {24'd0, mem_addr}, 32'h00);
        @(negedge clk);
        @(negedge clk);
        #1 clr = 1'b1;

        // Basic fetch, immediate ack.
        launch(8'h10);
        wait_done("basic_done", 20);
        check("basic_out", {24'd0, out}, 32'h5A);

        // Delayed ack: request must stay up until the load cycle.
        ack_delay = 3;
        launch(8'h10);
        req_drop = 1'b0;
        for (i = 0; i < 20; i++) begin
            @(negedge clk);
            #2;
            if (!ld) break;
            if (!mem_req) req_drop = 1'b1;
        end
        check("delay_req_held", 32'(req_drop), 32'd0);
        wait_done("delay_done", 20);
        check("delay_out", {24'd0, out}, 32'h5A);
        ack_delay = 0;

        // Address wrap with start held: two fetches, ld pulses four cycles apart.
        @(negedge clk);
        #1;
        start = 1'b1;
        addr  = 8'hFF;
        repeat (5) @(negedge clk);
        #1;
        start = 1'b0;
        wait_done("wrap_done", 20);
        check("wrap_out", {24'd0, out}, 32'hE7);

        // Timeout: no ack at all.
        ack_en = 1'b0;
        launch(8'h20);
        wait_done("to_done", 40);
        check("to_busy", 32'(busy), 32'd0);
        check("to_out_kept", {24'd0, out}, 32'hE7);
        ack_en = 1'b1;
        launch(8'h10);
        wait_done("after_to_done", 20);
        check("after_to_out", {24'd0, out}, 32'h5A);

        // Start while busy is ignored; clr during beat 1 aborts with no ld.
        ack_delay = 2;
        launch(8'h40);
        @(negedge clk);
        #1;
        start = 1'b1;
        addr  = 8'h80;
        @(negedge clk);
        #1;
        start = 1'b0;
        for (i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (mem_req && mem_addr == 8'h41) break;
        end
        check("mid_reach_beat1", 32'(i < 20), 32'd1);
        check("start_ignored", q.size(), 32'd1);
        #2 clr = 1'b0;
        #1 check_reset_outputs("mid_clr");
        q.delete();
        @(negedge clk);
        #1 clr = 1'b1;
        ack_delay = 0;
        repeat (3) @(negedge clk);
        check("mid_no_ld", 32'(q.size()), 32'd0);

        launch(8'h50);
        wait_done("final_done", 20);
        check("final_out", {24'd0, out}, 32'hC3);
        check("sb_empty", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
